// File: rtl/latsnq_ctrl_pkg.sv
// Shared types and helpers for the latch-bank write controller.
// Holds the sequencer state encoding, the grant class and the counter sizing.
package latsnq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_W_SETUP = 3'd1,
        ST_W_PULSE = 3'd2,
        ST_W_HOLD  = 3'd3,
        ST_P_PULSE = 3'd4,
        ST_P_RECOV = 3'd5
    } ctrl_state_e;

    typedef enum logic {
        GRANT_WRITE  = 1'b0,
        GRANT_PRESET = 1'b1
    } grant_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Down-counter width able to hold the longest phase length.
    function automatic int cnt_width(input int max_cyc);
        return $clog2(max_cyc) + 1;
    endfunction

endpackage

// File: rtl/latsnq_ctrl_arb.sv
// Two-way arbiter between the write and preset requesters.
// Offers the bus only while the sequencer is idle; on a tie (or with no
// request pending) the class that did not win last time is offered, so
// exactly one ready is high in every idle cycle.
module latsnq_ctrl_arb
    import latsnq_ctrl_pkg::*;
(
    input  logic   idle,
    input  logic   wr_valid,
    input  logic   pre_valid,
    input  grant_e last_grant,
    output logic   wr_ready,
    output logic   pre_ready
);

    // Select which requester sees ready this cycle.
    always_comb begin
        wr_ready  = 1'b0;
        pre_ready = 1'b0;
        if (idle) begin
            if (wr_valid && !pre_valid) begin
                wr_ready = 1'b1;
            end else if (pre_valid && !wr_valid) begin
                pre_ready = 1'b1;
            end else if (last_grant == GRANT_WRITE) begin
                pre_ready = 1'b1;
            end else begin
                wr_ready = 1'b1;
            end
        end
    end

endmodule

// File: rtl/latsnq_bank_wr_ctrl.sv
// Write/preset sequencer for a bank of set-capable transparent latches.
// Drives every E and SETN pin of the array from registers, stretching each
// phase (setup, pulse, hold, SETN recovery) to a whole number of CLK cycles.
// Optional access counters: define LATSNQ_WRCTRL_STATS_EN.
module latsnq_bank_wr_ctrl
    import latsnq_ctrl_pkg::*;
#(
    parameter int NWORDS    = 8,
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int REC_CYC   = 1,
    parameter int ADDR_W    = $clog2(NWORDS)
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [WIDTH-1:0]  WR_DATA,
    input  logic              PRE_VALID,
    output logic              PRE_READY,
    output logic [WIDTH-1:0]  LAT_D,
    output logic [NWORDS-1:0] LAT_E,
    output logic              LAT_SETN,
    output logic              BUSY
`ifdef LATSNQ_WRCTRL_STATS_EN
    ,
    output logic [15:0]       WR_CNT,
    output logic [15:0]       PRE_CNT
`endif
);

    localparam int CNT_W = cnt_width(max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, REC_CYC));

    ctrl_state_e        state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    grant_e             last_grant_reg, last_grant_next;
    logic [ADDR_W-1:0]  addr_reg;
    logic [WIDTH-1:0]   lat_d_reg;
    logic [NWORDS-1:0]  lat_e_reg, lat_e_next;
    logic               lat_setn_reg, lat_setn_next;
    logic [NWORDS-1:0]  word_hit;
    logic               wr_ready, pre_ready;
    logic               wr_fire, pre_fire;
    logic               cnt_zero;

    latsnq_ctrl_arb u_arb (
        .idle       (RN && (state_reg == ST_IDLE)),
        .wr_valid   (WR_VALID),
        .pre_valid  (PRE_VALID),
        .last_grant (last_grant_reg),
        .wr_ready   (wr_ready),
        .pre_ready  (pre_ready)
    );

    assign WR_READY  = wr_ready;
    assign PRE_READY = pre_ready;
    assign wr_fire   = WR_VALID && wr_ready;
    assign pre_fire  = PRE_VALID && pre_ready;
    assign cnt_zero  = (cnt_reg == '0);

    // Address decode; an out-of-range address matches no word, so the write is dropped.
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_dec
        assign word_hit[gi] = (32'(addr_reg) == 32'(gi));
    end

    // Next-state, phase counter and next latch-pin values.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            ST_IDLE: begin
                if (wr_fire) begin
                    state_next      = ST_W_SETUP;
                    cnt_next        = CNT_W'(SETUP_CYC - 1);
                    last_grant_next = GRANT_WRITE;
                end else if (pre_fire) begin
                    state_next      = ST_P_PULSE;
                    cnt_next        = CNT_W'(PULSE_CYC - 1);
                    last_grant_next = GRANT_PRESET;
                end
            end
            ST_W_SETUP: begin
                if (cnt_zero) begin
                    state_next = ST_W_PULSE;
                    cnt_next   = CNT_W'(PULSE_CYC - 1);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_W_PULSE: begin
                if (cnt_zero) begin
                    state_next = ST_W_HOLD;
                    cnt_next   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_W_HOLD: begin
                if (cnt_zero) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_P_PULSE: begin
                if (cnt_zero) begin
                    state_next = ST_P_RECOV;
                    cnt_next   = CNT_W'(REC_CYC - 1);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_P_RECOV: begin
                if (cnt_zero) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
        // Pins follow the state being entered so they are registered with it;
        // E and SETN therefore can never be active together.
        lat_e_next    = (state_next == ST_W_PULSE) ? word_hit : '0;
        lat_setn_next = (state_next != ST_P_PULSE);
    end

    // State, counter and latch-facing output registers.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            last_grant_reg <= GRANT_WRITE;
            addr_reg       <= '0;
            lat_d_reg      <= '0;
            lat_e_reg      <= '0;
            lat_setn_reg   <= 1'b1;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            last_grant_reg <= last_grant_next;
            lat_e_reg      <= lat_e_next;
            lat_setn_reg   <= lat_setn_next;
            if (wr_fire) begin
                addr_reg  <= WR_ADDR;
                lat_d_reg <= WR_DATA;
            end
        end
    end

    assign LAT_D    = lat_d_reg;
    assign LAT_E    = lat_e_reg;
    assign LAT_SETN = lat_setn_reg;
    assign BUSY     = (state_reg != ST_IDLE);

`ifdef LATSNQ_WRCTRL_STATS_EN
    logic [15:0] wr_cnt_reg;
    logic [15:0] pre_cnt_reg;

    // Saturating accept counters.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            wr_cnt_reg  <= '0;
            pre_cnt_reg <= '0;
        end else begin
            if (wr_fire && (wr_cnt_reg != 16'hFFFF)) begin
                wr_cnt_reg <= wr_cnt_reg + 16'd1;
            end
            if (pre_fire && (pre_cnt_reg != 16'hFFFF)) begin
                pre_cnt_reg <= pre_cnt_reg + 16'd1;
            end
        end
    end

    assign WR_CNT  = wr_cnt_reg;
    assign PRE_CNT = pre_cnt_reg;
`endif

endmodule
